// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input router / output serializer pair:
// sample type, control state encoding and the index bit-reversal helper.
package fft_pkg;

  localparam int S_WIDTH_DEF = 16;
  localparam int BITREV_MAX  = 16;

  typedef struct packed {
    logic [S_WIDTH_DEF-1:0] re;
    logic [S_WIDTH_DEF-1:0] im;
  } sample_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Reverse the low 'width' bits of idx; bits at and above 'width' come back zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] idx,
                                                   input int unsigned width);
    logic [BITREV_MAX-1:0] rev;
    rev = {BITREV_MAX{1'b0}};
    for (int unsigned i = 0; i < BITREV_MAX; i++) begin
      if (i < width) begin
        rev[i] = idx[width - 32'd1 - i];
      end else begin
        rev[i] = 1'b0;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/bit_reverse_index.sv
// Combinational LOG_2_WIDTH-bit index reversal used to address the frame
// buffer when undoing the FFT's bit-reversed output order.
module bit_reverse_index
  import fft_pkg::*;
#(
  parameter int LOG_2_WIDTH = 6
) (
  input  logic [LOG_2_WIDTH-1:0] idx,
  output logic [LOG_2_WIDTH-1:0] rev
);

  logic [BITREV_MAX-1:0]             wide_s;
  logic [BITREV_MAX-LOG_2_WIDTH-1:0] unused_hi_s;

  // Widen, reverse through the shared helper, then keep the low bits.
  always_comb begin
    wide_s      = bitrev(BITREV_MAX'(idx), LOG_2_WIDTH);
    rev         = wide_s[LOG_2_WIDTH-1:0];
    unused_hi_s = wide_s[BITREV_MAX-1:LOG_2_WIDTH];
  end

endmodule

// File: rtl/fft_output_serializer.sv
// Captures a full FFT frame and streams it out one sample per beat in
// natural bin order over valid/ready, with back-to-back frame acceptance.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int S_WIDTH     = S_WIDTH_DEF,
  parameter int BIT_REVERSE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [D_WIDTH-1:0][S_WIDTH-1:0]  in_Re,
  input  logic [D_WIDTH-1:0][S_WIDTH-1:0]  in_Im,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [S_WIDTH-1:0]               out_Re,
  output logic [S_WIDTH-1:0]               out_Im,
  output logic [LOG_2_WIDTH-1:0]           out_index,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy
);

  state_e                          state_r;
  state_e                          state_nx_s;
  logic [LOG_2_WIDTH-1:0]          k_r;
  logic [LOG_2_WIDTH-1:0]          rev_s;
  logic [LOG_2_WIDTH-1:0]          perm_s;
  logic [D_WIDTH-1:0][S_WIDTH-1:0] buf_re_r;
  logic [D_WIDTH-1:0][S_WIDTH-1:0] buf_im_r;
  logic                            streaming_s;
  logic                            last_s;
  logic                            beat_s;
  logic                            accept_s;

  bit_reverse_index #(
    .LOG_2_WIDTH (LOG_2_WIDTH)
  ) u_bit_reverse_index (
    .idx (k_r),
    .rev (rev_s)
  );

  // Handshake decode; a new frame may land on the final beat's handshake.
  always_comb begin
    streaming_s = (state_r == STREAM);
    last_s      = streaming_s && (k_r == LOG_2_WIDTH'(D_WIDTH - 1));
    beat_s      = streaming_s && out_ready;
    in_ready    = (state_r == IDLE) || (last_s && out_ready);
    accept_s    = in_valid && in_ready;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = STREAM;
        end else begin
          state_nx_s = IDLE;
        end
      end
      STREAM: begin
        if (beat_s && last_s && !accept_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = STREAM;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Beat counter; wraps to zero when the last beat completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r <= {LOG_2_WIDTH{1'b0}};
    end else if (accept_s) begin
      k_r <= {LOG_2_WIDTH{1'b0}};
    end else if (beat_s) begin
      k_r <= last_s ? {LOG_2_WIDTH{1'b0}} : k_r + LOG_2_WIDTH'(1);
    end
  end

  // Frame buffer, written only when a frame is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_re_r <= {(D_WIDTH*S_WIDTH){1'b0}};
      buf_im_r <= {(D_WIDTH*S_WIDTH){1'b0}};
    end else if (accept_s) begin
      buf_re_r <= in_Re;
      buf_im_r <= in_Im;
    end
  end

  // Read mux: beat k shows buffer slot bitrev(k) or k.
  always_comb begin
    if (BIT_REVERSE != 0) begin
      perm_s = rev_s;
    end else begin
      perm_s = k_r;
    end
    out_Re    = buf_re_r[perm_s];
    out_Im    = buf_im_r[perm_s];
    out_index = k_r;
    out_valid = streaming_s;
    out_last  = last_s;
    busy      = streaming_s;
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer: bit-reversed and identity
// instances share stimulus; expected values are computed by the bench.
module tb_fft_output_serializer;

  localparam int N  = 64;
  localparam int LW = 6;
  localparam int SW = 16;

  logic                    clk;
  logic                    rst;
  logic [N-1:0][SW-1:0]    in_re;
  logic [N-1:0][SW-1:0]    in_im;
  logic                    in_valid;
  logic                    out_ready;

  logic                    in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [SW-1:0]           out_re_b, out_im_b;
  logic [LW-1:0]           out_index_b;
  logic                    in_ready_i, out_valid_i, out_last_i, busy_i;
  logic [SW-1:0]           out_re_i, out_im_i;
  logic [LW-1:0]           out_index_i;

  int total;
  int bad;

  fft_output_serializer #(.D_WIDTH(N), .LOG_2_WIDTH(LW), .S_WIDTH(SW), .BIT_REVERSE(1)) dut_rev (
    .clk(clk), .rst(rst), .in_Re(in_re), .in_Im(in_im), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_Re(out_re_b), .out_Im(out_im_b), .out_index(out_index_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b), .busy(busy_b)
  );

  fft_output_serializer #(.D_WIDTH(N), .LOG_2_WIDTH(LW), .S_WIDTH(SW), .BIT_REVERSE(0)) dut_id (
    .clk(clk), .rst(rst), .in_Re(in_re), .in_Im(in_im), .in_valid(in_valid),
    .in_ready(in_ready_i), .out_Re(out_re_i), .out_Im(out_im_i), .out_index(out_index_i),
    .out_valid(out_valid_i), .out_ready(out_ready), .out_last(out_last_i), .busy(busy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rev6(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) begin
      if (x[b]) r = r | (1 << (5 - b));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int re_base, input int im_base, input bit im_desc);
    for (int i = 0; i < N; i++) begin
      in_re[i] = SW'(re_base + i);
      in_im[i] = im_desc ? SW'(64 - i) : SW'(im_base + i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int exp_k;
    int stall;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_frame(0, 0, 1'b1);

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready_b), 32'd1);
    chk("rst_out_valid", 32'(out_valid_b), 32'd0);
    chk("rst_out_last", 32'(out_last_b), 32'd0);
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_out_index", 32'(out_index_b), 32'd0);
    chk("rst_out_re", 32'(out_re_b), 32'd0);
    chk("rst_out_im", 32'(out_im_b), 32'd0);
    rst = 1'b1;
    tick();

    // Frame 1: full stream, both orderings
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready_b), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("f1_first_bin1_const", 32'(rev6(1)), 32'd32);
    for (int k = 0; k < N; k++) begin
      chk("f1_valid", 32'(out_valid_b), 32'd1);
      chk("f1_index", 32'(out_index_b), 32'(k));
      chk("f1_re", 32'(out_re_b), 32'(rev6(k)));
      chk("f1_im", 32'(out_im_b), 32'(64 - rev6(k)));
      chk("f1_last", 32'(out_last_b), 32'(k == N - 1));
      chk("f1_busy", 32'(busy_b), 32'd1);
      chk("id_re", 32'(out_re_i), 32'(k));
      chk("id_im", 32'(out_im_i), 32'(64 - k));
      if (k == 1) chk("f1_beat1_re", 32'(out_re_b), 32'd32);
      if (k == 3) chk("f1_beat3_re", 32'(out_re_b), 32'd48);
      tick();
    end
    chk("f1_end_valid", 32'(out_valid_b), 32'd0);
    chk("f1_end_busy", 32'(busy_b), 32'd0);
    chk("f1_end_in_ready", 32'(in_ready_b), 32'd1);
    chk("f1_end_index", 32'(out_index_b), 32'd0);
    chk("id_end_valid", 32'(out_valid_i), 32'd0);

    // Frame 2: backpressure at beat 5, rejected frame pulse at beat 20
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc   = 0;
    exp_k = 0;
    stall = 0;
    while (out_valid_b && cyc < 200) begin
      chk("bp_index", 32'(out_index_b), 32'(exp_k));
      chk("bp_re", 32'(out_re_b), 32'(rev6(exp_k)));
      chk("bp_im", 32'(out_im_b), 32'(64 - rev6(exp_k)));
      if (exp_k == 5 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (exp_k == 20 && out_ready) begin
        set_frame(500, 700, 1'b0);
        in_valid = 1'b1;
        #1;
        chk("busy_in_ready", 32'(in_ready_b), 32'd0);
      end
      tick();
      in_valid = 1'b0;
      cyc++;
      if (out_ready) exp_k++;
    end
    chk("bp_cycles", 32'(cyc), 32'd67);
    chk("bp_beats", 32'(exp_k), 32'd64);
    chk("bp_end_valid", 32'(out_valid_b), 32'd0);

    // Frames 3 and 4: back-to-back with the second frame held valid
    out_ready = 1'b1;
    set_frame(0, 0, 1'b1);
    in_valid = 1'b1;
    tick();
    set_frame(100, 300, 1'b0);
    for (int k = 0; k < N; k++) begin
      chk("b2b_a_re", 32'(out_re_b), 32'(rev6(k)));
      chk("b2b_in_ready", 32'(in_ready_b), 32'(k == N - 1));
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_no_bubble_valid", 32'(out_valid_b), 32'd1);
    chk("b2b_beat64_re", 32'(out_re_b), 32'd100);
    chk("b2b_beat64_im", 32'(out_im_b), 32'd300);
    chk("b2b_beat64_index", 32'(out_index_b), 32'd0);
    for (int k = 0; k < N; k++) begin
      chk("b2b_b_re", 32'(out_re_b), 32'(100 + rev6(k)));
      chk("b2b_b_id_re", 32'(out_re_i), 32'(100 + k));
      tick();
    end
    chk("b2b_end_valid", 32'(out_valid_b), 32'd0);

    // Reset mid-stream at beat 10, then immediate new frame
    set_frame(0, 0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid_index_pre", 32'(out_index_b), 32'd10);
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid_b), 32'd0);
    chk("mid_index", 32'(out_index_b), 32'd0);
    chk("mid_busy", 32'(busy_b), 32'd0);
    chk("mid_in_ready", 32'(in_ready_b), 32'd1);
    chk("mid_re", 32'(out_re_b), 32'd0);
    #1;
    rst = 1'b1;
    set_frame(50, 80, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid_b), 32'd1);
    chk("post_rst_re", 32'(out_re_b), 32'd50);
    chk("post_rst_im", 32'(out_im_b), 32'd80);
    tick();
    chk("post_rst_beat1_re", 32'(out_re_b), 32'd82);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_output_serializer.md
# fft_output_serializer

Output-side counterpart to the FFT input signal router. Takes one complete 64-point complex frame from the FFT core as parallel arrays and captures it in a frame buffer. Streams the frame out one sample per cycle over a valid/ready interface, undoing the bit-reversed ordering so that samples leave in natural frequency-bin order. Sits between the last butterfly stage and any downstream consumer (host interface, magnitude unit).

## Interface
- D_WIDTH, 64, points per frame (power of two)
- LOG_2_WIDTH, 6, log2(D_WIDTH); width of sample index
- S_WIDTH, 16, bits per real/imaginary component (two's complement)
- BIT_REVERSE, 1, 1 = emit buffer[bitrev(k)] at beat k; 0 = emit buffer[k]
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_Re  input  [S_WIDTH-1:0] x D_WIDTH  frame real parts, element i = FFT output slot i
- in_Im  input  [S_WIDTH-1:0] x D_WIDTH  frame imaginary parts
- in_valid  input  1  frame on in_Re/in_Im is valid
- in_ready  output  1  block accepts a frame this cycle
- out_Re  output  S_WIDTH  current sample real part
- out_Im  output  S_WIDTH  current sample imaginary part
- out_index  output  LOG_2_WIDTH  natural-order bin number k of current sample
- out_valid  output  1  out_* carry a valid sample
- out_ready  input  1  consumer takes sample this cycle
- out_last  output  1  current sample is bin D_WIDTH-1
- busy  output  1  frame held, streaming in progress

## Operation
- States: IDLE, STREAM. Beat counter k (LOG_2_WIDTH bits).
- IDLE: in_ready=1, out_valid=0. On in_valid: copy all D_WIDTH Re/Im into buffer, k<=0, go STREAM.
- STREAM: out_valid=1; out_Re/out_Im = buffer[perm(k)], with perm = bitrev when BIT_REVERSE=1, identity otherwise; out_index=k; out_last = (k==D_WIDTH-1).
- Beat completes on out_valid & out_ready: k<=k+1. out_ready low: k, buffer and all out_* hold stable.
- Last beat completing (k==D_WIDTH-1): without new frame, go IDLE, k<=0. Buffer keeps old contents, but out_valid=0.
- Back-to-back: in_ready = IDLE | (STREAM & out_last & out_ready). A frame accepted on the last-beat handshake overwrites the buffer and stays in STREAM with k<=0. No bubble cycle.
- in_valid while in_ready=0: ignored; frame not captured. Upstream must hold it.
- No arithmetic on samples; values pass bit-exact.
- busy = (state==STREAM).

## Timing
- Reset (rst=0, asynchronous): state IDLE, k=0, buffer cleared to 0. Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, out_index=0, out_Re=out_Im=0.
- Reset mid-stream: frame abandoned, no further beats. After release, the block accepts a new frame immediately.
- Latency: frame accepted at edge N; first sample valid in the cycle after edge N.
- Throughput: D_WIDTH cycles per frame with out_ready held high, continuous across frames.
- All outputs are functions of registered state only (buffer, k, state), except in_ready, which depends combinationally on out_ready.

## Structure
- fft_pkg holds:
  - S_WIDTH default
  - sample_t typedef (packed Re/Im pair)
  - state enum {IDLE, STREAM}
  - bitrev function parameterised on LOG_2_WIDTH, shared with the input router
- One sub-module: bit_reverse_index. Combinational LOG_2_WIDTH-bit reversal feeding the buffer read mux; instantiated so it can be unit-tested alone.
- Top holds the FSM, counter, buffer and read mux.

## Test plan
- Reset then idle: rst low -> in_ready=1, out_valid=0, out_Re=0. Assert rst low mid-stream at k=10 -> out_valid drops immediately and k=0.
- Bit-reverse order: in_Re[i]=i, in_Im[i]=64-i, out_ready=1, BIT_REVERSE=1 -> out_Re sequence 0,32,16,48,8,…,63 and out_Im = 64-out_Re. out_index runs 0..63; out_last only on beat 63. Next cycle in IDLE.
- Identity mode: BIT_REVERSE=0, same frame -> out_Re = 0,1,2,…,63.
- Backpressure: drop out_ready for 3 cycles at k=5 -> out_Re/out_index stay stable at beat 5. Frame completes in 67 cycles with no lost or duplicated sample.
- Back-to-back: second frame (in_Re[i]=100+i) held valid throughout -> in_ready only high on beat 63. Beat 64 emits 100 with no bubble.
- Busy rejection: pulse in_valid with a different frame at k=20 -> ignored; remaining beats still come from frame 1.
